// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-address width, ALU operation encodings and
// the packed pipeline control bundle with its all-zero bubble value.
package cpu_pkg;

   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLT = 3'd5,
      ALU_NOR = 3'd6,
      ALU_LUI = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic [2:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the destination
// of a load currently sitting in EX. Purely combinational.
module load_use_detect
   import cpu_pkg::*;
(
   input  logic                  valid_id_i,
   input  logic                  valid_ex_i,
   input  logic                  memread_ex_i,
   input  logic [REG_ADDR_W-1:0] rd_ex_i,
   input  logic [REG_ADDR_W-1:0] rs_i,
   input  logic [REG_ADDR_W-1:0] rt_i,
   input  logic                  uses_rt_i,
   output logic                  hz_o
);

   logic rs_match;
   logic rt_match;

   always_comb begin
      rs_match = (rd_ex_i == rs_i);
      rt_match = uses_rt_i & (rd_ex_i == rt_i);
      // R0 is hardwired zero, so a load targeting it never produces a dependency
      hz_o     = valid_id_i & valid_ex_i & memread_ex_i & (rd_ex_i != '0)
                 & (rs_match | rt_match);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush squash and load-use bubble insertion.
// Hazard detection, stall_o and the stall counter exist only with IDEX_HAZARD_EN.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              valid_i,
   input  logic              flush_i,
   input  logic [4:0]        RSaddr_i,
   input  logic [4:0]        RTaddr_i,
   input  logic              uses_rt_i,
   input  logic [DATA_W-1:0] RSdata_i,
   input  logic [DATA_W-1:0] RTdata_i,
   input  logic [DATA_W-1:0] imm_i,
   input  logic [4:0]        RDaddr_i,
   input  logic              RegWrite_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic              MemtoReg_i,
   input  logic              ALUSrc_i,
   input  logic [2:0]        ALUOp_i,
   output logic              valid_o,
   output logic [4:0]        RSaddr_o,
   output logic [4:0]        RTaddr_o,
   output logic [DATA_W-1:0] RSdata_o,
   output logic [DATA_W-1:0] RTdata_o,
   output logic [DATA_W-1:0] imm_o,
   output logic [4:0]        RDaddr_o,
   output logic              RegWrite_o,
   output logic              MemRead_o,
   output logic              MemWrite_o,
   output logic              MemtoReg_o,
   output logic              ALUSrc_o,
   output logic [2:0]        ALUOp_o,
   output logic              stall_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   logic              hz;
   logic              valid_q, valid_d;
   ctrl_t             ctrl_q, ctrl_d, ctrl_in;
   logic [4:0]        rs_addr_q, rt_addr_q, rd_addr_q;
   logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;

`ifdef IDEX_HAZARD_EN
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   load_use_detect u_load_use_detect (
      .valid_id_i   (valid_i),
      .valid_ex_i   (valid_q),
      .memread_ex_i (ctrl_q.mem_read),
      .rd_ex_i      (rd_addr_q),
      .rs_i         (RSaddr_i),
      .rt_i         (RTaddr_i),
      .uses_rt_i    (uses_rt_i),
      .hz_o         (hz)
   );

   always_comb begin
      cnt_d = cnt_q;
      if (hz && !flush_i && !(&cnt_q))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign stall_cnt_o = cnt_q;
`else
   logic unused_uses_rt;

   assign hz             = 1'b0;
   assign unused_uses_rt = uses_rt_i;
   assign stall_cnt_o    = '0;
`endif

   assign stall_o = hz & ~flush_i;

   always_comb begin
      ctrl_in.reg_write  = RegWrite_i;
      ctrl_in.mem_read   = MemRead_i;
      ctrl_in.mem_write  = MemWrite_i;
      ctrl_in.mem_to_reg = MemtoReg_i;
      ctrl_in.alu_src    = ALUSrc_i;
      ctrl_in.alu_op     = ALUOp_i;

      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
      // Flush and load-use both yield a bubble; only the accepted path carries control
      if (!flush_i && !hz) begin
         valid_d = valid_i;
         ctrl_d  = valid_i ? ctrl_in : CTRL_NOP;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q   <= 1'b0;
         ctrl_q    <= CTRL_NOP;
         rs_addr_q <= '0;
         rt_addr_q <= '0;
         rd_addr_q <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         ctrl_q    <= ctrl_d;
         rs_addr_q <= RSaddr_i;
         rt_addr_q <= RTaddr_i;
         rd_addr_q <= RDaddr_i;
         rs_data_q <= RSdata_i;
         rt_data_q <= RTdata_i;
         imm_q     <= imm_i;
      end
   end

   assign valid_o    = valid_q;
   assign RSaddr_o   = rs_addr_q;
   assign RTaddr_o   = rt_addr_q;
   assign RDaddr_o   = rd_addr_q;
   assign RSdata_o   = rs_data_q;
   assign RTdata_o   = rt_data_q;
   assign imm_o      = imm_q;
   assign RegWrite_o = ctrl_q.reg_write;
   assign MemRead_o  = ctrl_q.mem_read;
   assign MemWrite_o = ctrl_q.mem_write;
   assign MemtoReg_o = ctrl_q.mem_to_reg;
   assign ALUSrc_o   = ctrl_q.alu_src;
   assign ALUOp_o    = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow whether
// IDEX_HAZARD_EN is defined for the build. Counter width reduced to 4 bits.
module tb_id_ex_stage;

`ifdef IDEX_HAZARD_EN
   localparam bit HZ = 1'b1;
`else
   localparam bit HZ = 1'b0;
`endif
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          valid_i, flush_i, uses_rt_i;
   logic [4:0]    RSaddr_i, RTaddr_i, RDaddr_i;
   logic [DW-1:0] RSdata_i, RTdata_i, imm_i;
   logic          RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUSrc_i;
   logic [2:0]    ALUOp_i;
   logic          valid_o;
   logic [4:0]    RSaddr_o, RTaddr_o, RDaddr_o;
   logic [DW-1:0] RSdata_o, RTdata_o, imm_o;
   logic          RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o;
   logic [2:0]    ALUOp_o;
   logic          stall_o;
   logic [CW-1:0] stall_cnt_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .flush_i(flush_i),
      .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .uses_rt_i(uses_rt_i),
      .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .imm_i(imm_i), .RDaddr_i(RDaddr_i),
      .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
      .MemtoReg_i(MemtoReg_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
      .valid_o(valid_o), .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o),
      .RSdata_o(RSdata_o), .RTdata_o(RTdata_o), .imm_o(imm_o), .RDaddr_o(RDaddr_o),
      .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
      .MemtoReg_o(MemtoReg_o), .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
      .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_load(input logic [4:0] rd);
      valid_i = 1'b1; flush_i = 1'b0; uses_rt_i = 1'b0;
      RSaddr_i = 5'd1; RTaddr_i = rd; RDaddr_i = rd;
      RSdata_i = 32'h0000_1000; RTdata_i = 32'h0; imm_i = 32'h0000_0004;
      RegWrite_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0;
      MemtoReg_i = 1'b1; ALUSrc_i = 1'b1; ALUOp_i = 3'd0;
   endtask

   task automatic drive_alu(input logic [4:0] rs, input logic [4:0] rt,
                            input logic use_rt, input logic [4:0] rd);
      valid_i = 1'b1; flush_i = 1'b0; uses_rt_i = use_rt;
      RSaddr_i = rs; RTaddr_i = rt; RDaddr_i = rd;
      RSdata_i = 32'h1111_1111; RTdata_i = 32'h2222_2222; imm_i = 32'hFFFF_FFF0;
      RegWrite_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0;
      MemtoReg_i = 1'b0; ALUSrc_i = 1'b0; ALUOp_i = 3'd2;
   endtask

   initial begin
      rst_n = 1'b0;
      drive_alu(5'd0, 5'd0, 1'b0, 5'd0);
      valid_i = 1'b0;
      #2;
      chk("reset_valid", {31'd0, valid_o}, 32'd0);
      chk("reset_cnt", {28'd0, stall_cnt_o}, 32'd0);
      chk("reset_stall", {31'd0, stall_o}, 32'd0);
      step();
      chk("reset_held_rd", {27'd0, RDaddr_o}, 32'd0);
      rst_n = 1'b1;

      // Load R8, then a dependent add on RS
      drive_load(5'd8);
      step();
      chk("load_valid", {31'd0, valid_o}, 32'd1);
      chk("load_memread", {31'd0, MemRead_o}, 32'd1);
      chk("load_rd", {27'd0, RDaddr_o}, 32'd8);
      drive_alu(5'd8, 5'd9, 1'b1, 5'd10);
      #1;
      chk("rs_dep_stall", {31'd0, stall_o}, {31'd0, HZ});
      step();
      chk("bubble_valid", {31'd0, valid_o}, {31'd0, !HZ});
      chk("bubble_regwrite", {31'd0, RegWrite_o}, {31'd0, !HZ});
      chk("bubble_memread", {31'd0, MemRead_o}, 32'd0);
      chk("cnt_after_one", {28'd0, stall_cnt_o}, HZ ? 32'd1 : 32'd0);
      chk("stall_released", {31'd0, stall_o}, 32'd0);
      step();
      chk("add_valid", {31'd0, valid_o}, 32'd1);
      chk("add_rd", {27'd0, RDaddr_o}, 32'd10);
      chk("add_rsdata", RSdata_o, 32'h1111_1111);
      chk("add_aluop", {29'd0, ALUOp_o}, 32'd2);

      // RT match gated by uses_rt_i; then flush beats hazard
      drive_load(5'd8);
      step();
      drive_alu(5'd3, 5'd8, 1'b0, 5'd11);
      #1;
      chk("rt_unused_nostall", {31'd0, stall_o}, 32'd0);
      uses_rt_i = 1'b1;
      #1;
      chk("rt_used_stall", {31'd0, stall_o}, {31'd0, HZ});
      flush_i = 1'b1;
      #1;
      chk("flush_kills_stall", {31'd0, stall_o}, 32'd0);
      step();
      chk("flush_valid", {31'd0, valid_o}, 32'd0);
      chk("flush_regwrite", {31'd0, RegWrite_o}, 32'd0);
      chk("flush_cnt", {28'd0, stall_cnt_o}, HZ ? 32'd1 : 32'd0);

      // Load to R0 never stalls
      drive_load(5'd0);
      step();
      drive_alu(5'd0, 5'd0, 1'b1, 5'd12);
      #1;
      chk("r0_nostall", {31'd0, stall_o}, 32'd0);

      // Invalid ID instruction carries no control
      drive_alu(5'd4, 5'd5, 1'b1, 5'd13);
      valid_i = 1'b0; MemWrite_i = 1'b1;
      step();
      chk("invalid_memwrite", {31'd0, MemWrite_o}, 32'd0);
      chk("invalid_regwrite", {31'd0, RegWrite_o}, 32'd0);

      // Saturation: 19 further load-use pairs on a 4-bit counter
      for (int i = 0; i < 19; i++) begin
         drive_load(5'd8);
         step();
         drive_alu(5'd8, 5'd1, 1'b0, 5'd14);
         step();
      end
      chk("cnt_saturated", {28'd0, stall_cnt_o}, HZ ? 32'h0000_000F : 32'd0);
      drive_load(5'd8);
      step();
      drive_alu(5'd8, 5'd1, 1'b0, 5'd14);
      step();
      chk("cnt_still_sat", {28'd0, stall_cnt_o}, HZ ? 32'h0000_000F : 32'd0);

      // Asynchronous reset mid-cycle with a load in EX
      drive_load(5'd8);
      step();
      chk("pre_reset_valid", {31'd0, valid_o}, 32'd1);
      drive_alu(5'd8, 5'd2, 1'b0, 5'd15);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", {31'd0, valid_o}, 32'd0);
      chk("async_memread", {31'd0, MemRead_o}, 32'd0);
      chk("async_cnt", {28'd0, stall_cnt_o}, 32'd0);
      chk("async_rsdata", RSdata_o, 32'd0);
      chk("async_stall", {31'd0, stall_o}, 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      chk("post_reset_nostall", {31'd0, stall_o}, 32'd0);
      step();
      chk("post_reset_accept", {27'd0, RDaddr_o}, 32'd15);
      chk("post_reset_valid", {31'd0, valid_o}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
